// File: rtl/axi4lite_reg_slice_if.sv
// AXI4-Lite bundle without bresp/rresp, used on both sides of axi4lite_reg_slice.
// The master modport drives the request channels (AW/W/AR) and the response readies (B/R).
interface axi4lite_reg_slice_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi4lite_reg_slice.sv
// AXI4-Lite register slice: a 2-entry skid buffer per channel (AW, W, B, AR, R).
// Define AXI4LITE_REG_SLICE_STATS_EN to add upstream read/write response counters.

module axi4lite_reg_slice_skid #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [W-1:0] src_data,
  output logic         snk_valid,
  input  logic         snk_ready,
  output logic [W-1:0] snk_data
);
  logic         out_valid, skid_valid, ready_q;
  logic         out_valid_nx, skid_valid_nx;
  logic [W-1:0] out_data, skid_data;
  logic         in_acc, out_free;

  assign in_acc    = src_valid && ready_q;
  assign out_free  = !out_valid || snk_ready;
  assign src_ready = ready_q;
  assign snk_valid = out_valid;
  assign snk_data  = out_data;

  always_comb begin
    out_valid_nx  = out_valid;
    skid_valid_nx = skid_valid;
    if (out_free) begin
      out_valid_nx  = skid_valid || in_acc;
      skid_valid_nx = skid_valid && in_acc;
    end else if (in_acc) begin
      skid_valid_nx = 1'b1;
    end
  end

  // Ready is a flop of the next skid state, so sink ready never reaches src_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      out_valid  <= out_valid_nx;
      skid_valid <= skid_valid_nx;
      ready_q    <= !skid_valid_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (out_free && (skid_valid || in_acc))
      out_data <= skid_valid ? skid_data : src_data;
    if (in_acc && (skid_valid || !out_free))
      skid_data <= src_data;
  end
endmodule

module axi4lite_reg_slice #(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [4:0] CHANNEL_MASK = 5'b11111
) (
  input  logic                 clk,
  input  logic                 reset,
  axi4lite_reg_slice_if.slave  s_axi,
  axi4lite_reg_slice_if.master m_axi
`ifdef AXI4LITE_REG_SLICE_STATS_EN
  ,
  output logic [31:0]          stat_rd_count,
  output logic [31:0]          stat_wr_count
`endif
);
  localparam int AX_W = ADDR_WIDTH + 3;
  localparam int WD_W = DATA_WIDTH + DATA_WIDTH / 8;

  generate
    if (CHANNEL_MASK[0]) begin : g_aw
      logic [AX_W-1:0] snk;
      axi4lite_reg_slice_skid #(.W(AX_W)) u_skid (
        .clk(clk), .reset(reset),
        .src_valid(s_axi.awvalid), .src_ready(s_axi.awready),
        .src_data({s_axi.awaddr, s_axi.awprot}),
        .snk_valid(m_axi.awvalid), .snk_ready(m_axi.awready), .snk_data(snk)
      );
      assign {m_axi.awaddr, m_axi.awprot} = snk;
    end else begin : g_aw_wire
      assign m_axi.awvalid = s_axi.awvalid;
      assign s_axi.awready = m_axi.awready;
      assign m_axi.awaddr  = s_axi.awaddr;
      assign m_axi.awprot  = s_axi.awprot;
    end

    if (CHANNEL_MASK[1]) begin : g_w
      logic [WD_W-1:0] snk;
      axi4lite_reg_slice_skid #(.W(WD_W)) u_skid (
        .clk(clk), .reset(reset),
        .src_valid(s_axi.wvalid), .src_ready(s_axi.wready),
        .src_data({s_axi.wdata, s_axi.wstrb}),
        .snk_valid(m_axi.wvalid), .snk_ready(m_axi.wready), .snk_data(snk)
      );
      assign {m_axi.wdata, m_axi.wstrb} = snk;
    end else begin : g_w_wire
      assign m_axi.wvalid = s_axi.wvalid;
      assign s_axi.wready = m_axi.wready;
      assign m_axi.wdata  = s_axi.wdata;
      assign m_axi.wstrb  = s_axi.wstrb;
    end

    // B carries no payload; a constant bit keeps the same buffer and synthesizes away.
    if (CHANNEL_MASK[2]) begin : g_b
      logic unused_b;
      axi4lite_reg_slice_skid #(.W(1)) u_skid (
        .clk(clk), .reset(reset),
        .src_valid(m_axi.bvalid), .src_ready(m_axi.bready), .src_data(1'b0),
        .snk_valid(s_axi.bvalid), .snk_ready(s_axi.bready), .snk_data(unused_b)
      );
    end else begin : g_b_wire
      assign s_axi.bvalid = m_axi.bvalid;
      assign m_axi.bready = s_axi.bready;
    end

    if (CHANNEL_MASK[3]) begin : g_ar
      logic [AX_W-1:0] snk;
      axi4lite_reg_slice_skid #(.W(AX_W)) u_skid (
        .clk(clk), .reset(reset),
        .src_valid(s_axi.arvalid), .src_ready(s_axi.arready),
        .src_data({s_axi.araddr, s_axi.arprot}),
        .snk_valid(m_axi.arvalid), .snk_ready(m_axi.arready), .snk_data(snk)
      );
      assign {m_axi.araddr, m_axi.arprot} = snk;
    end else begin : g_ar_wire
      assign m_axi.arvalid = s_axi.arvalid;
      assign s_axi.arready = m_axi.arready;
      assign m_axi.araddr  = s_axi.araddr;
      assign m_axi.arprot  = s_axi.arprot;
    end

    if (CHANNEL_MASK[4]) begin : g_r
      axi4lite_reg_slice_skid #(.W(DATA_WIDTH)) u_skid (
        .clk(clk), .reset(reset),
        .src_valid(m_axi.rvalid), .src_ready(m_axi.rready), .src_data(m_axi.rdata),
        .snk_valid(s_axi.rvalid), .snk_ready(s_axi.rready), .snk_data(s_axi.rdata)
      );
    end else begin : g_r_wire
      assign s_axi.rvalid = m_axi.rvalid;
      assign m_axi.rready = s_axi.rready;
      assign s_axi.rdata  = m_axi.rdata;
    end
  endgenerate

`ifdef AXI4LITE_REG_SLICE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rd_count <= '0;
      stat_wr_count <= '0;
    end else begin
      if (s_axi.rvalid && s_axi.rready) stat_rd_count <= stat_rd_count + 32'd1;
      if (s_axi.bvalid && s_axi.bready) stat_wr_count <= stat_wr_count + 32'd1;
    end
  end
`endif
endmodule
